// File: rtl/ps2_receptor_teclado_if.sv
// Decoded keyboard output bundle: make code, strobe, E0 flag and frame-error strobe.
interface ps2_receptor_teclado_if;
  logic [7:0] Cambio;
  logic       got_data;
  logic       extended;
  logic       frame_error;

  modport master (output Cambio, got_data, extended, frame_error);
  modport slave  (input  Cambio, got_data, extended, frame_error);
endinterface

// File: rtl/ps2_receptor_teclado.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deserialise 11-bit frames,
// swallow break sequences (F0 xx) and flag E0-prefixed make codes.
module ps2_receptor_teclado #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_receptor_teclado_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_clk, filt_prev, fall;
  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift;
  logic                  par;
  logic [CW-1:0]         tmo_cnt;
  logic                  brk_flag, ext_flag;

  // Pins idle high, so the whole conditioning chain presets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_reg  <= '1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      filt_reg  <= {filt_reg[FILTER_LEN-2:0], clk_s2};
      if (filt_reg == '1)      filt_clk <= 1'b1;
      else if (filt_reg == '0) filt_clk <= 1'b0;
      filt_prev <= filt_clk;
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Decoding happens on the STOP-bit fall edge so got_data appears the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift           <= '0;
      par             <= 1'b0;
      tmo_cnt         <= '0;
      brk_flag        <= 1'b0;
      ext_flag        <= 1'b0;
      bus.Cambio      <= 8'h00;
      bus.got_data    <= 1'b0;
      bus.extended    <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      bus.got_data    <= 1'b0;
      bus.frame_error <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && ((^shift) ^ par)) begin
              if (shift == 8'hF0) begin
                brk_flag <= 1'b1;
              end else if (shift == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (brk_flag) begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
              end else begin
                bus.Cambio   <= shift;
                bus.extended <= ext_flag;
                bus.got_data <= 1'b1;
                ext_flag     <= 1'b0;
              end
            end else begin
              bus.frame_error <= 1'b1;
              brk_flag        <= 1'b0;
              ext_flag        <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled keyboard must not leave a half frame to be completed by the next one.
        if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_receptor_teclado.sv
// Directed bench: bit-banged PS/2 frames with hand-computed parity and expected strobes.
module tb_ps2_receptor_teclado;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_receptor_teclado_if bus ();

  ps2_receptor_teclado #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int cmp = 0, mis = 0;
  int gd_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int gd_run = 0, gd_max = 0, fe_run = 0, fe_max = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_ext = 1'b0;
  int gd0, fe0;

  always @(negedge clk) begin
    if (bus.got_data) begin
      gd_cnt++;
      last_code = bus.Cambio;
      last_ext  = bus.extended;
      gd_run++;
    end else gd_run = 0;
    if (bus.frame_error) fe_run++; else fe_run = 0;
    if (bus.frame_error) fe_cnt++;
    if (bus.got_data && bus.frame_error) both_cnt++;
    if (gd_run > gd_max) gd_max = gd_run;
    if (fe_run > fe_max) fe_max = fe_run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(30);
  endtask

  task automatic mark();
    gd0 = gd_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    cyc(3);
    #1;
    chk("reset_cambio", {24'd0, bus.Cambio}, 32'h00);
    chk("reset_got_data", {31'd0, bus.got_data}, 32'd0);
    chk("reset_extended", {31'd0, bus.extended}, 32'd0);
    chk("reset_frame_error", {31'd0, bus.frame_error}, 32'd0);
    rst = 1'b0;
    cyc(20);

    // Plain make code 73 (five ones -> parity 0)
    mark();
    send_frame(8'h73, 1'b0);
    chk("m73_count", gd_cnt - gd0, 1);
    chk("m73_code", {24'd0, last_code}, 32'h73);
    chk("m73_ext", {31'd0, last_ext}, 32'd0);
    chk("m73_fe", fe_cnt - fe0, 0);

    // Make then break: 72 / F0 72
    mark();
    send_frame(8'h72, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h72, 1'b1);
    chk("brk_count", gd_cnt - gd0, 1);
    chk("brk_code", {24'd0, last_code}, 32'h72);
    chk("brk_cambio_hold", {24'd0, bus.Cambio}, 32'h72);

    // Extended make code E0 75, then plain 73
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("ext_count", gd_cnt - gd0, 1);
    chk("ext_code", {24'd0, last_code}, 32'h75);
    chk("ext_flag", {31'd0, last_ext}, 32'd1);
    mark();
    send_frame(8'h73, 1'b0);
    chk("after_ext_count", gd_cnt - gd0, 1);
    chk("after_ext_flag", {31'd0, last_ext}, 32'd0);

    // Parity error: preload Cambio with 72 first
    send_frame(8'h72, 1'b1);
    mark();
    send_frame(8'h73, 1'b1);
    chk("par_fe_count", fe_cnt - fe0, 1);
    chk("par_gd_count", gd_cnt - gd0, 0);
    chk("par_cambio_hold", {24'd0, bus.Cambio}, 32'h72);

    // Typematic repeat
    mark();
    send_frame(8'h73, 1'b0);
    send_frame(8'h73, 1'b0);
    chk("repeat_count", gd_cnt - gd0, 2);

    // Partial frame abandoned by timeout
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(TMO + 500);
    send_frame(8'h73, 1'b0);
    chk("tmo_count", gd_cnt - gd0, 1);
    chk("tmo_code", {24'd0, last_code}, 32'h73);
    chk("tmo_fe", fe_cnt - fe0, 0);

    // Reset mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_cambio", {24'd0, bus.Cambio}, 32'h00);
    chk("midrst_got_data", {31'd0, bus.got_data}, 32'd0);
    chk("midrst_extended", {31'd0, bus.extended}, 32'd0);
    chk("midrst_frame_error", {31'd0, bus.frame_error}, 32'd0);
    cyc(3);
    rst = 1'b0;
    ps2_data = 1'b1;
    cyc(20);
    mark();
    send_frame(8'h73, 1'b0);
    chk("postrst_count", gd_cnt - gd0, 1);
    chk("postrst_code", {24'd0, last_code}, 32'h73);

    // 2-cycle clock glitch with data low must not start a frame
    mark();
    ps2_data = 1'b0;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
    cyc(30);
    ps2_data = 1'b1;
    cyc(20);
    send_frame(8'h75, 1'b0);
    chk("glitch_count", gd_cnt - gd0, 1);
    chk("glitch_code", {24'd0, last_code}, 32'h75);
    chk("glitch_fe", fe_cnt - fe0, 0);

    chk("strobe_overlap", both_cnt, 0);
    chk("gd_max_width", gd_max, 1);
    chk("fe_max_width", fe_max, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/ps2_receptor_teclado.md
Name: ps2_receptor_teclado

Overview:
Upstream stage of the date/time adjust counters (month, day, year, hour). It deserialises PS/2 keyboard frames from the ps2_clk/ps2_data pins. Make codes are presented on Cambio with a one-cycle got_data strobe. Break sequences (F0 xx) are swallowed, so a key release never re-triggers an increment or decrement downstream. The E0 prefix is reported on a flag.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised ps2_clk samples required to change the filtered clock level (3..16).
TIMEOUT, 50000, clk cycles without a filtered falling edge after which a partial frame is discarded (~1 ms at 50 MHz).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock pin; asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin; asynchronous to clk.
Cambio  output  8  last accepted make code; holds its value between strobes.
got_data  output  1  one-cycle strobe; Cambio and extended are valid in the same cycle.
extended  output  1  1 when the strobed code was preceded by E0.
frame_error  output  1  one-cycle strobe on a parity or stop-bit error.

Behaviour:
- Reset (async, rst=1): Cambio=8'h00, got_data=0, extended=0, frame_error=0. FSM goes to IDLE. Break and extended flags clear. Filter register and filtered clock are preset to 1. Timeout counter clears. Reset mid-frame abandons the frame and produces no strobe.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Synchronised ps2_clk shifts into a FILTER_LEN-bit register.
  - Filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - fall = filtered clock transitions 1->0. fall is one cycle wide and is the only sampling event.
- Frame FSM; each listed action occurs on fall, reading synchronised ps2_data:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (spurious start ignored, no error).
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: check stop=1 and odd parity (XOR of 8 data bits and parity bit = 1).
    - Pass: hand the byte to the decoder.
    - Fail: frame_error=1 for one cycle; clear break and extended flags.
    - Either way -> IDLE.
  - Timeout counter resets on every fall and increments while the FSM is not in IDLE. Reaching TIMEOUT -> IDLE, byte discarded, no strobe, no frame_error, flags unchanged.
- Decoder, acting on a valid byte in the cycle after the STOP fall:
  - 8'hF0: set break flag; no strobe.
  - 8'hE0: set extended flag; no strobe.
  - Any other byte with break flag set: clear both flags; no strobe; Cambio unchanged.
  - Any other byte with break flag clear: Cambio<=byte, extended<=extended flag, got_data=1 for exactly one cycle; clear extended flag.
- Latency: got_data rises exactly 1 clk cycle after the cycle in which the STOP-bit fall is detected. Pin-to-fall delay is 2 sync stages + FILTER_LEN samples.
- got_data and frame_error are never high together; neither lasts more than one cycle.
- Repeated make codes from typematic repeat each produce a strobe. The downstream counter counts every one.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fall.

Test Plan:
- Frame for 8'h73: start 0, data 1,1,0,0,1,1,1,0, parity 0, stop 1 -> one got_data pulse with Cambio=8'h73, extended=0, frame_error=0.
- Sequence 72 / F0 72 (parity 1 for both bytes) -> exactly one got_data pulse, Cambio=8'h72. No strobe for F0 or the trailing 72.
- Sequence E0 75 (E0 parity 0, 75 parity 0) -> one strobe with Cambio=8'h75, extended=1. A following plain 73 frame -> extended=0.
- 8'h73 frame with parity forced to 1 -> frame_error one-cycle pulse, no got_data, Cambio keeps its previous value.
- Stop clocking after the 4th data bit for more than TIMEOUT cycles, then send a clean 73 frame -> no strobe for the partial frame, correct strobe with Cambio=8'h73 afterwards.
- Assert rst mid-frame (after bit 5) -> all outputs 0 immediately. The next full 73 frame is decoded correctly. A 2-cycle low glitch on ps2_clk in IDLE causes no state change.
